// File: rtl/ram_dualport_pipe.sv
// True dual-port RAM with valid/ready request ports,
// a fixed-latency read pipeline and a post-reset clear sweep.
module ram_dualport_pipe #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 64,
  parameter int BYTE_WIDTH    = 8,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_MODE    = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic                             init_done,
  input  logic                             req_valid_1,
  output logic                             req_ready_1,
  input  logic [ADDR_WIDTH-1:0]            req_addr_1,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] req_strobe_1,
  input  logic [DATA_WIDTH-1:0]            req_wdata_1,
  output logic                             resp_valid_1,
  output logic [DATA_WIDTH-1:0]            resp_rdata_1,
  input  logic                             req_valid_2,
  output logic                             req_ready_2,
  input  logic [ADDR_WIDTH-1:0]            req_addr_2,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] req_strobe_2,
  input  logic [DATA_WIDTH-1:0]            req_wdata_2,
  output logic                             resp_valid_2,
  output logic [DATA_WIDTH-1:0]            resp_rdata_2
);

  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam int NW = 2 ** ADDR_WIDTH;
  localparam int CW = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 1 : 1;
  localparam int L  = READ_LATENCY;

  localparam logic [CW-1:0] CNT_LAST = CW'(NW / 2 - 1);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_INIT  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_run;

  logic [DATA_WIDTH-1:0] r_mem [NW];

  logic [L-1:0]          r_vld [2];
  logic [DATA_WIDTH-1:0] r_dat [2][L];

  logic                  w_valid [2];
  logic [ADDR_WIDTH-1:0] w_addr  [2];
  logic [NB-1:0]         w_strb  [2];
  logic [DATA_WIDTH-1:0] w_wdat  [2];
  logic [1:0]            w_acc;
  logic [1:0]            w_wr;
  logic [DATA_WIDTH-1:0] w_old   [2];
  logic [DATA_WIDTH-1:0] w_new   [2];
  logic [DATA_WIDTH-1:0] w_rd    [2];
  logic                  w_sweep;
  logic [ADDR_WIDTH-1:0] w_sw_lo;
  logic [ADDR_WIDTH-1:0] w_sw_hi;

  assign w_valid[0] = req_valid_1;
  assign w_valid[1] = req_valid_2;
  assign w_addr[0]  = req_addr_1;
  assign w_addr[1]  = req_addr_2;
  assign w_strb[0]  = req_strobe_1;
  assign w_strb[1]  = req_strobe_2;
  assign w_wdat[0]  = req_wdata_1;
  assign w_wdat[1]  = req_wdata_2;

  assign init_done   = r_run;
  assign req_ready_1 = r_run;
  assign req_ready_2 = r_run;

  // a request arriving with reset low is never taken
  assign w_acc[0] = w_valid[0] && r_run && reset;
  assign w_acc[1] = w_valid[1] && r_run && reset;
  assign w_wr[0]  = w_acc[0] && (|w_strb[0]);
  assign w_wr[1]  = w_acc[1] && (|w_strb[1]);

  assign w_sweep = (r_state == S_INIT) && reset;
  assign w_sw_lo = ADDR_WIDTH'({r_cnt, 1'b0});
  assign w_sw_hi = w_sw_lo | ADDR_WIDTH'(1);

  // control FSM: reset -> optional clear sweep -> run
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_RESET;
      r_cnt   <= '0;
      r_run   <= 1'b0;
    end else begin
      unique case (r_state)
        S_RESET: begin
          r_cnt <= '0;
          if (INIT_ON_RESET != 0) begin
            r_state <= S_INIT;
            r_run   <= 1'b0;
          end else begin
            r_state <= S_RUN;
            r_run   <= 1'b1;
          end
        end
        S_INIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= S_RUN;
            r_run   <= 1'b1;
          end
        end
        S_RUN: begin
          r_run <= 1'b1;
        end
        default: begin
          r_state <= S_RESET;
          r_run   <= 1'b0;
        end
      endcase
    end
  end

  // post-write word seen at each port address; port 1 wins shared lanes
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_old[p] = r_mem[w_addr[p]];
      w_new[p] = w_old[p];
      for (int b = 0; b < NB; b++) begin
        if (w_wr[1] && (w_addr[1] == w_addr[p]) && w_strb[1][b]) begin
          w_new[p][b*BYTE_WIDTH +: BYTE_WIDTH] =
            w_wdat[1][b*BYTE_WIDTH +: BYTE_WIDTH];
        end
        if (w_wr[0] && (w_addr[0] == w_addr[p]) && w_strb[0][b]) begin
          w_new[p][b*BYTE_WIDTH +: BYTE_WIDTH] =
            w_wdat[0][b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
      w_rd[p] = (WRITE_MODE != 0) ? w_new[p] : w_old[p];
    end
  end

  // storage: sweep clears two words per cycle, else merged port writes
  always_ff @(posedge clk) begin
    if (w_sweep) begin
      r_mem[w_sw_lo] <= '0;
      r_mem[w_sw_hi] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (w_wr[p]) begin
          r_mem[w_addr[p]] <= w_new[p];
        end
      end
    end
  end

  // response pipeline; data stages only move with a valid so outputs hold
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int p = 0; p < 2; p++) begin
        r_vld[p] <= '0;
        for (int i = 0; i < L; i++) begin
          r_dat[p][i] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        r_vld[p][0] <= w_acc[p];
        if (w_acc[p]) begin
          r_dat[p][0] <= w_rd[p];
        end
        for (int i = 1; i < L; i++) begin
          r_vld[p][i] <= r_vld[p][i-1];
          if (r_vld[p][i-1]) begin
            r_dat[p][i] <= r_dat[p][i-1];
          end
        end
      end
    end
  end

  assign resp_valid_1 = r_vld[0][L-1];
  assign resp_valid_2 = r_vld[1][L-1];
  assign resp_rdata_1 = r_dat[0][L-1];
  assign resp_rdata_2 = r_dat[1][L-1];

endmodule
